calc_display: RTL and testbench

- Display back end for the calculator.
- Consumes the calculator's 16-bit `result` and 2-bit `op_display` code.
- Converts `result` to five BCD digits with a sequential double-dabble engine.
- Time-multiplexes an 8-digit common-anode 7-segment display: value right-aligned on digits 0-4, operation symbol on digit 7.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/calc_display_bin2bcd_seq.sv | 91 +++++++++
 rtl/calc_display.sv | 114 +++++++++++
 tb/tb_calc_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator display back end.
//   - operation codes (also used by the calculator logic)
//   - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - converter state encoding
//   - digit_seg(): BCD nibble to segment pattern
package calc_pkg;

    // Operation codes presented on op_display
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    // Segment patterns, active low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ADD   = 7'b0001000;  // 'A'
    localparam logic [6:0] SEG_SUB   = 7'b0111111;  // '-'
    localparam logic [6:0] SEG_MUL   = 7'b0001001;  // 'H'

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Binary-to-BCD converter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Map one BCD nibble to its segment pattern; non-BCD codes show blank
    function automatic logic [6:0] digit_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 16-bit binary to
// five BCD digits, one bit per clock.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   bin   in   16-bit unsigned value to convert
//   bcd   out  20-bit committed BCD {d4,d3,d2,d1,d0}
//   busy  out  high while a conversion is running (17 cycles)
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        busy
);
    import calc_pkg::*;

    conv_state_e state_r;
    logic [15:0] last_val_r;
    logic [15:0] shreg_r;
    logic [19:0] work_r;
    logic [3:0]  bit_cnt_r;
    logic [19:0] bcd_r;
    logic        busy_r;

    // Add 3 to every nibble >= 5 so the following shift carries correctly
    function automatic logic [19:0] dabble_adjust(input logic [19:0] w);
        logic [19:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = w[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Converter FSM: start on a new value, shift 16 bits, then commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_val_r <= 16'd0;
            shreg_r    <= 16'd0;
            work_r     <= 20'd0;
            bit_cnt_r  <= 4'd0;
            bcd_r      <= 20'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Changes during a conversion are picked up here,
                    // so only complete results ever reach bcd
                    if (bin != last_val_r) begin
                        shreg_r    <= bin;
                        last_val_r <= bin;
                        work_r     <= 20'd0;
                        bit_cnt_r  <= 4'd0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    {work_r, shreg_r} <= {dabble_adjust(work_r), shreg_r} << 1;
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd15) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                COMMIT: begin
                    bcd_r   <= work_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign busy = busy_r;

endmodule

// File: rtl/calc_display.sv
// calc_display: display back end for the calculator. Converts the 16-bit
// result to BCD and scans an 8-digit common-anode 7-segment display:
// value right-aligned on digits 0-4 with leading-zero blanking, operation
// symbol on digit 7, digits 5-6 blank.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   result      in   16-bit unsigned value to show
//   op_display  in   operation code (none/add/sub/mul)
//   an          out  digit enables, active low, bit 0 = rightmost digit
//   seg         out  segments {g,f,e,d,c,b,a}, active low
//   dp_n        out  decimal point, active low, always off
//   bcd         out  committed BCD value {d4,d3,d2,d1,d0}
//   busy        out  conversion in progress
module calc_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic [1:0]  op_display,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [19:0] bcd,
    output logic        busy
);
    import calc_pkg::*;

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic [6:0]       seg_next_s;
    logic [19:0]      bcd_s;
    logic             busy_s;

    bin2bcd_seq u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .bin  (result),
        .bcd  (bcd_s),
        .busy (busy_s)
    );

    // Scan timing: dwell counter and active digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            idx_r      <= 3'd0;
        end else if (scan_cnt_r == CNT_MAX) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Segment content for the active digit; digit k>0 blanks when it and
    // every higher digit are zero, digit 0 always shows
    always_comb begin
        seg_next_s = SEG_BLANK;
        case (idx_r)
            3'd0: seg_next_s = digit_seg(bcd_s[3:0]);
            3'd1: begin
                if (bcd_s[19:4] != 16'd0) seg_next_s = digit_seg(bcd_s[7:4]);
                else                      seg_next_s = SEG_BLANK;
            end
            3'd2: begin
                if (bcd_s[19:8] != 12'd0) seg_next_s = digit_seg(bcd_s[11:8]);
                else                      seg_next_s = SEG_BLANK;
            end
            3'd3: begin
                if (bcd_s[19:12] != 8'd0) seg_next_s = digit_seg(bcd_s[15:12]);
                else                      seg_next_s = SEG_BLANK;
            end
            3'd4: begin
                if (bcd_s[19:16] != 4'd0) seg_next_s = digit_seg(bcd_s[19:16]);
                else                      seg_next_s = SEG_BLANK;
            end
            3'd7: begin
                case (op_display)
                    OP_NONE: seg_next_s = SEG_BLANK;
                    OP_ADD:  seg_next_s = SEG_ADD;
                    OP_SUB:  seg_next_s = SEG_SUB;
                    OP_MUL:  seg_next_s = SEG_MUL;
                    default: seg_next_s = SEG_BLANK;
                endcase
            end
            default: seg_next_s = SEG_BLANK;
        endcase
    end

    // Register anode and segment drive together so they switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 8'hFF;
            seg_r <= SEG_BLANK;
        end else begin
            an_r  <= ~(8'd1 << idx_r);
            seg_r <= seg_next_s;
        end
    end

    assign an   = an_r;
    assign seg  = seg_r;
    assign dp_n = 1'b1;
    assign bcd  = bcd_s;
    assign busy = busy_s;

endmodule

// File: tb/tb_calc_display.sv
module tb_calc_display;

    logic        clk;
    logic        rst;
    logic [15:0] result;
    logic [1:0]  op_display;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [19:0] bcd;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_H     = 7'b0001001;
    localparam logic [6:0] S_D [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    calc_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .result     (result),
        .op_display (op_display),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .bcd        (bcd),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait for a fresh arrival of digit pattern 'target' on an
    task automatic wait_digit(input logic [7:0] target);
        int budget;
        budget = 0;
        while (an == target && budget < 40) begin tick(); budget++; end
        while (an != target && budget < 80) begin tick(); budget++; end
        chk("wait_digit", {24'd0, an}, {24'd0, target});
    endtask

    task automatic show_digit(input string tag, input int k, input logic [6:0] exp);
        logic [7:0] pat;
        pat = ~(8'd1 << k);
        wait_digit(pat);
        chk(tag, {25'd0, seg}, {25'd0, exp});
    endtask

    int busy_cnt;
    int bad_bcd;
    logic [7:0] exp_an;

    initial begin
        rst = 1'b1; result = 16'd0; op_display = 2'd0;
        tick(); tick();
        chk("rst_an",   {24'd0, an},  32'hFF);
        chk("rst_seg",  {25'd0, seg}, 32'h7F);
        chk("rst_dp",   {31'd0, dp_n}, 32'd1);
        chk("rst_bcd",  {12'd0, bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // one full frame with value 0: only digit 0 lit, busy stays low
        busy_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (busy) busy_cnt++;
            exp_an = ~(8'd1 << ((k - 1) / 4));
            chk("frame_an", {24'd0, an}, {24'd0, exp_an});
            chk("frame_seg", {25'd0, seg}, {25'd0, (((k - 1) / 4) == 0) ? S_D[0] : S_BLANK});
        end
        chk("zero_busy", busy_cnt, 0);
        chk("zero_bcd", {12'd0, bcd}, 32'd0);

        // 0 -> 12345
        result = 16'd12345;
        busy_cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i == 1)  chk("b12345_busy_rise", {31'd0, busy}, 32'd1);
            if (i == 17) chk("b12345_not_yet", {12'd0, bcd}, 32'd0);
        end
        chk("b12345_bcd", {12'd0, bcd}, 32'h12345);
        chk("b12345_busy_cnt", busy_cnt, 17);
        chk("b12345_busy_low", {31'd0, busy}, 32'd0);
        show_digit("d4_1", 4, S_D[1]);
        show_digit("d3_2", 3, S_D[2]);
        show_digit("d2_3", 2, S_D[3]);
        show_digit("d1_4", 1, S_D[4]);
        show_digit("d0_5", 0, S_D[5]);

        // 65535 (0 - 1 underflow)
        result = 16'hFFFF;
        for (int i = 1; i <= 18; i++) tick();
        chk("b65535_bcd", {12'd0, bcd}, 32'h65535);
        show_digit("d4_6", 4, S_D[6]);
        show_digit("d0_5b", 0, S_D[5]);

        // 100, then 7 during the 5th busy cycle
        result = 16'd100;
        bad_bcd = 0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (bcd != 20'h65535 && bcd != 20'h00100 && bcd != 20'h00007) bad_bcd++;
            if (i == 5) begin
                chk("b100_busy5", {31'd0, busy}, 32'd1);
                result = 16'd7;
            end
            if (i == 17) chk("b100_not_yet", {12'd0, bcd}, 32'h65535);
            if (i == 18) begin
                chk("b100_bcd", {12'd0, bcd}, 32'h00100);
                chk("b100_busy_low", {31'd0, busy}, 32'd0);
            end
            if (i == 19) chk("b7_busy_rise", {31'd0, busy}, 32'd1);
            if (i == 35) chk("b7_not_yet", {12'd0, bcd}, 32'h00100);
        end
        chk("b7_bcd", {12'd0, bcd}, 32'h00007);
        chk("b7_no_glitch", bad_bcd, 0);
        show_digit("d2_blank", 2, S_BLANK);
        show_digit("d1_blank", 1, S_BLANK);
        show_digit("d0_7", 0, S_D[7]);

        // op symbol on digit 7, one cycle after each change
        wait_digit(8'h7F);
        chk("op0_seg", {25'd0, seg}, {25'd0, S_BLANK});
        op_display = 2'd1; tick();
        chk("op_add", {25'd0, seg}, {25'd0, S_A});
        op_display = 2'd2; tick();
        chk("op_sub", {25'd0, seg}, {25'd0, S_DASH});
        op_display = 2'd3; tick();
        chk("op_mul", {25'd0, seg}, {25'd0, S_H});
        wait_digit(8'h7F);
        chk("op_mul_hold", {25'd0, seg}, {25'd0, S_H});
        op_display = 2'd0; tick();
        chk("op_none", {25'd0, seg}, {25'd0, S_BLANK});

        // reset in the middle of converting 999
        result = 16'd999;
        tick(); tick(); tick();
        chk("b999_in_shift", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
        chk("mid_rst_an", {24'd0, an}, 32'hFF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("b999_bcd", {12'd0, bcd}, 32'h00999);
        chk("b999_busy_cnt", busy_cnt, 17);
        show_digit("d2_9", 2, S_D[9]);
        show_digit("d3_blank", 3, S_BLANK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
